ms_timer_bank: RTL
==================

# ms_timer_bank

Bank of independent millisecond delay timers sharing one clock, with a run-time duration per channel, retrigger, cancel and an optional periodic mode. It generalises the single-shot fixed-duration delay timer used for motor/servo settle delays. A single instance can serve every sequencing delay in the robot controller. Each channel produces a one-cycle `done` pulse and a level `busy`.

## Interface
- `CHANNELS`, 4: number of independent timer channels (1..16).
- `CLK_PER_MS`, 25000: clock cycles per millisecond tick (≥2; 25000 for the 25 MHz system clock).
- `DUR_W`, 11: width of each duration field, in ms.
- `clock`  in  1: system clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high; clears every channel to IDLE.
- `start`  in  CHANNELS: per-channel start/retrigger strobe, sampled each edge.
- `cancel`  in  CHANNELS: per-channel abort strobe.
- `periodic`  in  CHANNELS: per-channel mode, sampled only when `start` is accepted (0 = one-shot, 1 = auto-reload).
- `duration`  in  CHANNELS*DUR_W: channel i duration in ms at bits [i*DUR_W +: DUR_W], sampled only when `start` is accepted.
- `done`  out  CHANNELS: one-cycle expiry pulse per channel, registered.
- `busy`  out  CHANNELS: channel i is counting, registered.

## Operation
- Channels are fully independent; no arbitration and no shared counters.
- Per-channel states: IDLE, COUNTING.
- IDLE:
  - `start[i]` → latch `duration` slice D and `periodic[i]`, enter COUNTING, `busy[i]`=1 from next cycle.
- COUNTING:
  - Counts D*CLK_PER_MS cycles as a prescaler (CLK_PER_MS-1 down to 0) and an ms counter (D down to 0).
  - On expiry, pulse `done[i]` for one cycle.
  - One-shot: return to IDLE; `busy[i]` drops in the same cycle `done[i]` rises.
  - Periodic: reload D and prescaler; `busy` stays 1; the next `done` follows exactly D*CLK_PER_MS cycles later.
- Retrigger: `start[i]` while COUNTING discards the current count and reloads from the new `duration`/`periodic`. No `done` is emitted for the abandoned count, even if it would have expired in that same cycle.
- `cancel[i]` in any state → IDLE next cycle, no `done`. Cancel beats start in the same cycle.
- D = 0: `done` after the minimum latency of 1 cycle; the channel always returns to IDLE, even with `periodic`=1 (no zero-period oscillation).
- Durations are unsigned; the largest usable value is 2^DUR_W-1 ms. Durations do not wrap or saturate.

## Timing
- Reset values: `done`=0, `busy`=0, all counters 0, all channels IDLE. A mid-count reset drops `busy` next cycle and emits no `done`.
- Latency for `start` sampled at edge k:
  - `busy` is high after edge k+1.
  - For D≥1, `done` is high during the cycle after edge k+D*CLK_PER_MS, for exactly 1 cycle.
  - For D=0, `done` is high after edge k+1.
- Period in periodic mode: exactly D*CLK_PER_MS cycles between `done` rising edges, with no drift.
- `start` and `cancel` are level-sampled. A start held high for N cycles retriggers every cycle, so `done` occurs only after release.
- `done` of channel i never depends on the inputs of channel j≠i.

## Structure
- Shared package `rbot_timer_pkg`:
  - channel state encoding (IDLE/COUNTING);
  - localparam `CLK_PER_MS_25M` = 25000;
  - helper function for prescaler width, `$clog2(CLK_PER_MS)`.
- Sub-module `ms_timer_channel`: one channel (FSM, prescaler, ms counter, `done`/`busy` registers), parametrised by `CLK_PER_MS` and `DUR_W`.
- Top level: a generate loop of CHANNELS instances plus duration-bus slicing. No other logic.

## Test plan
- Bench parameters: CLK_PER_MS=10, DUR_W=8, CHANNELS=4.
- One-shot: start[0] at edge k, D=3 → `busy[0]` high from k+1; a single `done[0]` pulse after edge k+30; `busy[0]` low in that same cycle.
- Periodic + cancel: start[1], D=2, periodic=1 → `done[1]` after edges k+20, k+40, k+60. Cancel at k+45 → no further `done`, `busy[1]` low after k+46.
- Retrigger: start[2] D=5 at k, start[2] D=1 at k+48 → no `done` at k+50; `done[2]` after k+58 only.
- Edge cases:
  - start[3] with D=0, periodic=1 → exactly one `done[3]` after k+1, then IDLE.
  - start and cancel together → stays IDLE, no `done`.
- Independence/reset:
  - All four channels started at the same edge with D=1,2,3,4 → each `done` at its own D*10 with no cross-talk.
  - `reset` asserted at k+25 → all outputs 0 after k+26, and no later `done`.

Source files
------------

// File: rtl/rbot_timer_pkg.sv
// Shared definitions for the robot controller's millisecond timer channels.
package rbot_timer_pkg;

  typedef enum logic {
    CH_IDLE     = 1'b0,
    CH_COUNTING = 1'b1
  } ch_state_e;

  localparam int CLK_PER_MS_25M = 25000;

  // The prescaler counts CLK_PER_MS-1 down to 0.
  function automatic int prescaler_width(input int clk_per_ms);
    return $clog2(clk_per_ms);
  endfunction

endpackage

// File: rtl/ms_timer_channel.sv
// One millisecond delay channel: start/retrigger, cancel, optional auto-reload,
// registered one-cycle done pulse and busy level.
module ms_timer_channel
  import rbot_timer_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_25M,
  parameter int DUR_W      = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic             periodic,
  input  logic [DUR_W-1:0] duration,
  output logic             done,
  output logic             busy
);

  localparam int PRE_W = prescaler_width(CLK_PER_MS);
  localparam logic [PRE_W-1:0] PRE_FULL  = PRE_W'(CLK_PER_MS - 1);
  // The capture edge itself is the first cycle of the first millisecond.
  localparam logic [PRE_W-1:0] PRE_FIRST = PRE_W'(CLK_PER_MS - 2);

  ch_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             per_q, per_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // NOTE: every signal gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    dur_d   = dur_q;
    per_d   = per_q;
    done_d  = 1'b0;

    if (cancel) begin
      state_d = CH_IDLE;
      pre_d   = '0;
      ms_d    = '0;
    end else if (start) begin
      // A retrigger wins over an expiry falling in the same cycle.
      dur_d = duration;
      per_d = periodic;
      if (duration == '0) begin
        state_d = CH_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = CH_COUNTING;
        pre_d   = PRE_FIRST;
        ms_d    = duration - DUR_W'(1);
      end
    end else if (state_q == CH_COUNTING) begin
      if (pre_q != '0) begin
        pre_d = pre_q - PRE_W'(1);
      end else if (ms_q != '0) begin
        pre_d = PRE_FULL;
        ms_d  = ms_q - DUR_W'(1);
      end else begin
        done_d = 1'b1;
        if (per_q) begin
          // dur_q is never zero here: a zero duration never enters COUNTING.
          pre_d = PRE_FULL;
          ms_d  = dur_q - DUR_W'(1);
        end else begin
          state_d = CH_IDLE;
        end
      end
    end

    busy_d = (state_d == CH_COUNTING);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CH_IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      dur_q   <= dur_d;
      per_q   <= per_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/ms_timer_bank.sv
// Bank of independent millisecond delay timers; one channel instance per bit.
module ms_timer_bank
  import rbot_timer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CLK_PER_MS = CLK_PER_MS_25M,
  parameter int DUR_W      = 11
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*DUR_W-1:0] duration,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       busy
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ms_timer_channel #(
      .CLK_PER_MS(CLK_PER_MS),
      .DUR_W     (DUR_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .start   (start[i]),
      .cancel  (cancel[i]),
      .periodic(periodic[i]),
      .duration(duration[i*DUR_W +: DUR_W]),
      .done    (done[i]),
      .busy    (busy[i])
    );
  end

endmodule
